// File: rtl/frame_buffer_writer.sv
// Frame-buffer write port: buffers masked-pixel beats and drains them into VGA RAM.
// Tracks raster position, flags order/range errors and counts completed frames.
module frame_buffer_writer #(
  parameter int ROWS       = 240,
  parameter int COLS       = 320,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_pixel,
  input  logic [7:0]  in_row,
  input  logic [8:0]  in_col,
  input  logic        wr_grant,
  output logic        wr_en,
  output logic [7:0]  wr_row,
  output logic [8:0]  wr_col,
  output logic [11:0] wr_pixel,
  output logic        frame_done,
  output logic [7:0]  frame_count,
  output logic        seq_error,
  output logic        range_error,
  input  logic        clr_err,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL     = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  LAST_ROW = 8'(ROWS - 1);
  localparam logic [8:0]  LAST_COL = 9'(COLS - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  typedef struct packed {
    logic [11:0] pixel;
    logic [7:0]  row;
    logic [8:0]  col;
  } beat_t;

  beat_t         mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [0:0]    state;
  logic [7:0]    erow;
  logic [8:0]    ecol;

  logic  in_range;
  logic  accept;
  logic  push;
  logic  pop;
  beat_t head;
  logic  match;
  logic  last;
  logic [7:0] nrow;
  logic [8:0] ncol;

  // Ready depends on registered occupancy only, so a full FIFO
  // refuses a beat even when a pop happens on the same edge.
  assign in_ready = (count != FULL);
  assign in_range = (in_row <= LAST_ROW) && (in_col <= LAST_COL);
  assign accept   = in_valid && in_ready;
  assign push     = accept && in_range;
  assign pop      = (count != '0) && wr_grant;
  assign head     = mem[rptr];
  assign match    = (head.row == erow) && (head.col == ecol);
  assign last     = (head.row == LAST_ROW) && (head.col == LAST_COL);
  assign busy     = (state == ACTIVE) || (count != '0);

  // Raster position following the head entry; used to resync on error.
  always_comb begin
    nrow = head.row;
    ncol = head.col + 9'd1;
    if (head.col == LAST_COL) begin
      ncol = '0;
      nrow = (head.row == LAST_ROW) ? 8'd0 : head.row + 8'd1;
    end
  end

  // FIFO storage; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{pixel: in_pixel, row: in_row, col: in_col};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // RAM write port: registers the head entry on each pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_row     <= '0;
      wr_col     <= '0;
      wr_pixel   <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_en      <= pop;
      frame_done <= pop && last;
      if (pop) begin
        wr_row   <= head.row;
        wr_col   <= head.col;
        wr_pixel <= head.pixel;
      end
    end
  end

  // Frame state, expected raster position and frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      erow        <= '0;
      ecol        <= '0;
      frame_count <= '0;
    end else if (pop) begin
      erow <= nrow;
      ecol <= ncol;
      unique case (1'b1)
        last: begin
          state       <= IDLE;
          frame_count <= frame_count + 8'd1;
        end
        default: state <= ACTIVE;
      endcase
    end
  end

  // Sticky error flags; a new event outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_error   <= 1'b0;
      range_error <= 1'b0;
    end else begin
      if (clr_err) begin
        seq_error   <= 1'b0;
        range_error <= 1'b0;
      end
      if (pop && !match)        seq_error   <= 1'b1;
      if (accept && !in_range)  range_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer with a 4x5 frame.
// Per-cycle vector table plus sequences for frames, wrap and reset.
module tb_frame_buffer_writer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_pixel;
  logic [7:0]  in_row;
  logic [8:0]  in_col;
  logic        wr_grant;
  logic        wr_en;
  logic [7:0]  wr_row;
  logic [8:0]  wr_col;
  logic [11:0] wr_pixel;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic        seq_error;
  logic        range_error;
  logic        clr_err;
  logic        busy;

  frame_buffer_writer #(.ROWS(4), .COLS(5), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_row(in_row), .in_col(in_col),
    .wr_grant(wr_grant), .wr_en(wr_en),
    .wr_row(wr_row), .wr_col(wr_col), .wr_pixel(wr_pixel),
    .frame_done(frame_done), .frame_count(frame_count),
    .seq_error(seq_error), .range_error(range_error),
    .clr_err(clr_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  typedef struct packed {
    logic        done;
    logic [7:0]  r;
    logic [8:0]  c;
    logic [11:0] px;
  } wr_t;

  wr_t wq[$];
  int  nwr = 0;
  int  ndone = 0;

  always @(negedge clk) begin
    if (wr_en) begin
      wq.push_back('{done: frame_done, r: wr_row, c: wr_col, px: wr_pixel});
      nwr++;
      if (frame_done) ndone++;
    end
  end

  typedef struct {
    logic        rst, v, g, clr;
    logic [7:0]  r;
    logic [8:0]  c;
    logic [11:0] px;
    logic        rdy, we;
    logic [7:0]  er;
    logic [8:0]  ec;
    logic [11:0] epx;
    logic        seq, rng, bsy;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic rs, input logic v, input logic g, input logic cl,
    input logic [7:0] r, input logic [8:0] c, input logic [11:0] px,
    input logic rdy, input logic we,
    input logic [7:0] er, input logic [8:0] ec, input logic [11:0] epx,
    input logic sq, input logic rg, input logic bz);
    vec_t t;
    t.rst = rs; t.v = v; t.g = g; t.clr = cl;
    t.r = r; t.c = c; t.px = px;
    t.rdy = rdy; t.we = we;
    t.er = er; t.ec = ec; t.epx = epx;
    t.seq = sq; t.rng = rg; t.bsy = bz;
    return t;
  endfunction

  task automatic drive(input logic v, input logic [7:0] r,
                       input logic [8:0] c, input logic [11:0] px,
                       input logic g);
    @(negedge clk);
    in_valid = v; in_row = r; in_col = c; in_pixel = px; wr_grant = g;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; wr_grant = 1'b1; clr_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; wr_grant = 1'b1; clr_err = 1'b0;
    in_pixel = 12'h0; in_row = 8'd0; in_col = 9'd0;

    // Reset with in_valid held high.
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_fcnt", 32'(frame_count), 0);
    chk("rst_flags", {seq_error, range_error, frame_done}, 0);
    chk("rst_busy", 32'(busy), 0);

    // rst v g clr row col px | rdy we er ec epx seq rng busy
    tv.push_back(mk(1,1,1,0, 0,0,12'h000, 1,0, 0,0,12'h000, 0,0,0));
    // backpressure
    tv.push_back(mk(0,1,0,0, 0,0,12'h100, 1,0, 0,0,12'h000, 0,0,1));
    tv.push_back(mk(0,1,0,0, 0,1,12'h101, 1,0, 0,0,12'h000, 0,0,1));
    tv.push_back(mk(0,1,0,0, 0,2,12'h102, 1,0, 0,0,12'h000, 0,0,1));
    tv.push_back(mk(0,1,0,0, 0,3,12'h103, 1,0, 0,0,12'h000, 0,0,1));
    tv.push_back(mk(0,1,0,0, 0,4,12'h104, 0,0, 0,0,12'h000, 0,0,1));
    tv.push_back(mk(0,1,1,0, 0,4,12'h104, 0,1, 0,0,12'h100, 0,0,1));
    tv.push_back(mk(0,1,1,0, 0,4,12'h104, 1,1, 0,1,12'h101, 0,0,1));
    tv.push_back(mk(0,1,1,0, 1,0,12'h105, 1,1, 0,2,12'h102, 0,0,1));
    tv.push_back(mk(0,0,1,0, 0,0,12'h000, 1,1, 0,3,12'h103, 0,0,1));
    tv.push_back(mk(0,0,1,0, 0,0,12'h000, 1,1, 0,4,12'h104, 0,0,1));
    tv.push_back(mk(0,0,1,0, 0,0,12'h000, 1,1, 1,0,12'h105, 0,0,1));
    tv.push_back(mk(0,0,1,0, 0,0,12'h000, 1,0, 0,0,12'h000, 0,0,1));
    // mid-frame reset
    tv.push_back(mk(1,0,1,0, 0,0,12'h000, 1,0, 0,0,12'h000, 0,0,0));
    // order error, clear, clear vs new error
    tv.push_back(mk(0,1,1,0, 0,0,12'h200, 1,0, 0,0,12'h000, 0,0,1));
    tv.push_back(mk(0,1,1,0, 0,2,12'h201, 1,1, 0,0,12'h200, 0,0,1));
    tv.push_back(mk(0,1,1,0, 0,3,12'h202, 1,1, 0,2,12'h201, 1,0,1));
    tv.push_back(mk(0,0,1,1, 0,0,12'h000, 1,1, 0,3,12'h202, 0,0,1));
    tv.push_back(mk(0,1,1,0, 2,2,12'h203, 1,0, 0,0,12'h000, 0,0,1));
    tv.push_back(mk(0,0,1,1, 0,0,12'h000, 1,1, 2,2,12'h203, 1,0,1));
    tv.push_back(mk(0,0,1,0, 0,0,12'h000, 1,0, 0,0,12'h000, 1,0,1));
    tv.push_back(mk(1,0,1,0, 0,0,12'h000, 1,0, 0,0,12'h000, 0,0,0));
    // range error
    tv.push_back(mk(0,1,1,0, 4,0,12'h300, 1,0, 0,0,12'h000, 0,1,0));
    tv.push_back(mk(0,1,1,0, 0,0,12'h301, 1,0, 0,0,12'h000, 0,1,1));
    tv.push_back(mk(0,0,1,0, 0,0,12'h000, 1,1, 0,0,12'h301, 0,1,1));
    tv.push_back(mk(0,0,1,1, 0,0,12'h000, 1,0, 0,0,12'h000, 0,0,1));
    tv.push_back(mk(0,1,1,1, 0,5,12'h302, 1,0, 0,0,12'h000, 0,1,1));
    tv.push_back(mk(0,0,1,1, 0,0,12'h000, 1,0, 0,0,12'h000, 0,0,1));

    foreach (tv[i]) begin
      @(negedge clk);
      rst = tv[i].rst; in_valid = tv[i].v; wr_grant = tv[i].g;
      clr_err = tv[i].clr; in_row = tv[i].r; in_col = tv[i].c;
      in_pixel = tv[i].px;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'(tv[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we", i), 32'(wr_en), 32'(tv[i].we));
      if (tv[i].we)
        chk($sformatf("v%0d_wdata", i), {wr_row, wr_col, wr_pixel},
            {tv[i].er, tv[i].ec, tv[i].epx});
      chk($sformatf("v%0d_flags", i), {seq_error, range_error, busy, frame_done},
          {tv[i].seq, tv[i].rng, tv[i].bsy, 1'b0});
    end
    @(negedge clk);
    rst = 1'b0; clr_err = 1'b0; in_valid = 1'b0;

    // Full frame in raster order.
    do_reset();
    wq.delete();
    for (int i = 0; i < 20; i++)
      drive(1'b1, 8'(i / 5), 9'(i % 5), 12'(12'h040 + i), 1'b1);
    drive(1'b0, 8'd0, 9'd0, 12'h0, 1'b1);
    repeat (4) @(negedge clk);
    chk("frame_nwr", wq.size(), 20);
    for (int i = 0; i < 20 && i < wq.size(); i++)
      chk($sformatf("frame_w%0d", i), 32'(wq[i]),
          {i == 19, 8'(i / 5), 9'(i % 5), 12'(12'h040 + i)});
    chk("frame_count1", 32'(frame_count), 1);
    chk("frame_seq", 32'(seq_error), 0);
    chk("frame_busy", 32'(busy), 0);

    // Out-of-order last pixel still ends the frame.
    do_reset();
    wq.delete();
    drive(1'b1, 8'd3, 9'd4, 12'h7AB, 1'b1);
    drive(1'b0, 8'd0, 9'd0, 12'h0, 1'b1);
    repeat (3) @(negedge clk);
    chk("ooo_nwr", wq.size(), 1);
    if (wq.size() > 0) chk("ooo_done", 32'(wq[0].done), 1);
    chk("ooo_fcnt", 32'(frame_count), 1);
    chk("ooo_seq", 32'(seq_error), 1);
    chk("ooo_busy", 32'(busy), 0);

    // 256 frames wrap the counter, then reset mid-frame.
    do_reset();
    begin
      int d0;
      int w0;
      d0 = ndone;
      for (int f = 0; f < 256; f++)
        for (int i = 0; i < 20; i++)
          drive(1'b1, 8'(i / 5), 9'(i % 5), 12'(f), 1'b1);
      drive(1'b0, 8'd0, 9'd0, 12'h0, 1'b1);
      repeat (3) @(negedge clk);
      chk("wrap_fcnt", 32'(frame_count), 0);
      chk("wrap_ndone", ndone - d0, 256);
      chk("wrap_seq", 32'(seq_error), 0);
      for (int i = 0; i < 7; i++)
        drive(1'b1, 8'(i / 5), 9'(i % 5), 12'h0AA, i < 4);
      @(negedge clk);
      in_valid = 1'b0;
      chk("pre_rst_full", 32'(in_ready), 0);
      chk("pre_rst_busy", 32'(busy), 1);
      w0 = nwr;
      rst = 1'b1; wr_grant = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_rst_nwr", nwr, w0);
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_ready", 32'(in_ready), 1);
      wq.delete();
      drive(1'b1, 8'd0, 9'd0, 12'h555, 1'b1);
      drive(1'b0, 8'd0, 9'd0, 12'h0, 1'b1);
      repeat (3) @(negedge clk);
      chk("post_rst_w", nwr, w0 + 1);
      if (wq.size() > 0)
        chk("post_rst_data", 32'(wq[0]), {1'b0, 8'd0, 9'd0, 12'h555});
      chk("post_rst_seq", 32'(seq_error), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
